// File: rtl/delay_seq_pkg.sv
// ----------------------------------------------------------------------------
// delay_seq_pkg : shared constants, FSM state type and tap-offset helper
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package delay_seq_pkg;

  localparam int NTAPS  = 5;
  localparam int STEP_W = 4;
  localparam int WID_W  = 4;
  // Must hold NTAPS*(2^STEP_W-1) + 2^WID_W-1 = 90
  localparam int CNT_W  = 7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Cycle offset at which tap idx begins its low pulse: S*(idx+1)
  function automatic logic [CNT_W-1:0] tap_start(input logic [STEP_W-1:0] step,
                                                 input int unsigned       idx);
    return CNT_W'(step) * CNT_W'(idx + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/delay_tap_sequencer_tap_window.sv
// ----------------------------------------------------------------------------
// tap_window : registered active-low pulse, low while start <= cnt < start+W
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tap_window
  import delay_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic [CNT_W-1:0] i_start,
  input  logic [WID_W-1:0] i_width,
  output logic             o_tap_n
);

  logic [CNT_W-1:0] w_end;
  logic             w_active;
  logic             r_tap_n;

  // start+W tops out at 75+15, so CNT_W bits never wrap
  assign w_end    = i_start + CNT_W'(i_width);
  assign w_active = i_en && (i_cnt >= i_start) && (i_cnt < w_end);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tap_n <= 1'b1;
    end else begin
      r_tap_n <= ~w_active;
    end
  end

  assign o_tap_n = r_tap_n;

endmodule

`default_nettype wire

// File: rtl/delay_tap_sequencer.sv
// ----------------------------------------------------------------------------
// delay_tap_sequencer : trigger-edge driven five-tap active-low pulse scheduler
// Option macro: DELAY_SEQ_RETRIGGER_EN (edge during RUN restarts the sequence)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module delay_tap_sequencer
  import delay_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trig,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic [WID_W-1:0]  cfg_width,
  output logic [NTAPS-1:0]  tap_n,
  output logic              busy,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [STEP_W-1:0] r_step;
  logic [WID_W-1:0]  r_width;
  logic              r_trig_q;
  logic              r_overrun;

  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [STEP_W-1:0] w_step_nxt;
  logic [WID_W-1:0]  w_width_nxt;
  logic              w_ovr_nxt;
  logic              w_start;
  logic              w_edge;
  logic              w_last;
  logic [CNT_W-1:0]  w_len;
  logic [STEP_W-1:0] w_cfg_step;
  logic [WID_W-1:0]  w_cfg_width;

  assign w_edge      = trig & ~r_trig_q;
  assign w_cfg_step  = (cfg_step == '0)  ? STEP_W'(1) : cfg_step;
  assign w_cfg_width = (cfg_width == '0) ? WID_W'(1)  : cfg_width;
  assign w_len       = CNT_W'(NTAPS) * CNT_W'(r_step) + CNT_W'(r_width);
  // Final RUN cycle: the counter reaches L on the coming edge
  assign w_last      = (r_state == RUN) && (r_cnt == (w_len - c_ONE));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_step_nxt  = r_step;
    w_width_nxt = r_width;
    w_ovr_nxt   = 1'b0;
    w_start     = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_edge) begin
          w_start = 1'b1;
        end
      end
      RUN: begin
        if (w_edge && w_last) begin
          // Edge coinciding with completion is a fresh IDLE edge
          w_start = 1'b1;
        end else if (w_edge) begin
          w_ovr_nxt = 1'b1;
`ifdef DELAY_SEQ_RETRIGGER_EN
          w_start   = 1'b1;
`else
          w_cnt_nxt = r_cnt + c_ONE;
`endif
        end else begin
          w_cnt_nxt = r_cnt + c_ONE;
          if (w_last) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_start) begin
      w_state_nxt = RUN;
      w_cnt_nxt   = '0;
      w_step_nxt  = w_cfg_step;
      w_width_nxt = w_cfg_width;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_step    <= STEP_W'(1);
      r_width   <= WID_W'(1);
      r_trig_q  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_step    <= w_step_nxt;
      r_width   <= w_width_nxt;
      r_trig_q  <= trig;
      r_overrun <= w_ovr_nxt;
    end
  end

  // Windows see next-cycle count/config so each tap output is itself a register
  generate
    for (genvar i = 0; i < NTAPS; i++) begin : g_tap
      logic [CNT_W-1:0] w_tap_start;
      assign w_tap_start = tap_start(w_step_nxt, i);

      tap_window u_tap_window (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (w_state_nxt == RUN),
        .i_cnt   (w_cnt_nxt),
        .i_start (w_tap_start),
        .i_width (w_width_nxt),
        .o_tap_n (tap_n[i])
      );
    end
  endgenerate

  assign busy    = (r_state == RUN);
  assign overrun = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_delay_tap_sequencer.sv
// ----------------------------------------------------------------------------
// tb_delay_tap_sequencer : scoreboard bench for delay_tap_sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_delay_tap_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       trig;
  logic [3:0] cfg_step;
  logic [3:0] cfg_width;
  logic [4:0] tap_n;
  logic       busy;
  logic       overrun;

  typedef struct {
    logic [4:0] tap;
    logic       busy;
    logic       ovr;
    int         sc;
    int         j;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cur_sc = 0;

  // Hand-derived table for step=1, width=1, cycles j=1..6 after the edge
  logic [4:0] t1_tap  [6] = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111, 5'b11111};
  logic       t1_busy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  delay_tap_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .trig      (trig),
    .cfg_step  (cfg_step),
    .cfg_width (cfg_width),
    .tap_n     (tap_n),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Expected tap_n j cycles after the trigger edge: tap i low for j in [S(i+1), S(i+1)+W)
  function automatic logic [4:0] exp_tap(input int j, input int s, input int w);
    logic [4:0] r;
    r = 5'b11111;
    for (int i = 0; i < 5; i++) begin
      if (j >= s * (i + 1) && j < s * (i + 1) + w) r[i] = 1'b0;
    end
    return r;
  endfunction

  task automatic cyc(input logic t, input logic [4:0] tap, input logic b,
                     input logic o, input int j);
    exp_t e;
    trig   = t;
    e.tap  = tap;
    e.busy = b;
    e.ovr  = o;
    e.sc   = cur_sc;
    e.j    = j;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic seq_expect(input int s, input int w, input int j0, input int j1);
    for (int j = j0; j <= j1; j++) begin
      cyc(1'b0, exp_tap(j, s, w), (j < 5 * s + w), 1'b0, j);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 5'b11111, 1'b0, 1'b0, 100 + k);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (tap_n !== e.tap || busy !== e.busy || overrun !== e.ovr) begin
          n_bad++;
          $display("FAIL sc%0d j%0d: got tap_n=%b busy=%b overrun=%b, expected tap_n=%b busy=%b overrun=%b",
                   e.sc, e.j, tap_n, busy, overrun, e.tap, e.busy, e.ovr);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    trig      = 1'b0;
    cfg_step  = 4'd0;
    cfg_width = 4'd0;

    cur_sc = 0;
    cyc(1'b0, 5'b11111, 1'b0, 1'b0, 0);
    cyc(1'b0, 5'b11111, 1'b0, 1'b0, 1);
    reset_n = 1'b1;
    idle(2);

    // step=1 width=1 from hand table
    cur_sc = 1; cfg_step = 4'd1; cfg_width = 4'd1;
    cyc(1'b1, 5'b11111, 1'b1, 1'b0, 0);
    for (int j = 1; j <= 6; j++) cyc(1'b0, t1_tap[j-1], t1_busy[j-1], 1'b0, j);
    idle(2);

    // step=3 width=5, overlapping windows; config change mid-run must not matter
    cur_sc = 2; cfg_step = 4'd3; cfg_width = 4'd5;
    cyc(1'b1, 5'b11111, 1'b1, 1'b0, 0);
    cfg_step = 4'd7; cfg_width = 4'd9;
    seq_expect(3, 5, 1, 22);

    // zero config behaves as 1/1
    cur_sc = 3; cfg_step = 4'd0; cfg_width = 4'd0;
    cyc(1'b1, 5'b11111, 1'b1, 1'b0, 0);
    seq_expect(1, 1, 1, 8);

    // second edge four cycles in
    cur_sc = 4; cfg_step = 4'd2; cfg_width = 4'd2;
    cyc(1'b1, 5'b11111, 1'b1, 1'b0, 0);
    seq_expect(2, 2, 1, 3);
`ifdef DELAY_SEQ_RETRIGGER_EN
    cyc(1'b1, 5'b11111, 1'b1, 1'b1, 4);
    for (int jj = 1; jj <= 13; jj++) begin
      cyc(1'b0, exp_tap(jj, 2, 2), (jj < 12), 1'b0, jj + 4);
    end
`else
    cyc(1'b1, exp_tap(4, 2, 2), 1'b1, 1'b1, 4);
    seq_expect(2, 2, 5, 14);
`endif

    // back-to-back: edge exactly at k+L, busy must stay high
    cur_sc = 5; cfg_step = 4'd1; cfg_width = 4'd1;
    cyc(1'b1, 5'b11111, 1'b1, 1'b0, 0);
    seq_expect(1, 1, 1, 5);
    cfg_step = 4'd2;
    cyc(1'b1, 5'b11111, 1'b1, 1'b0, 6);
    seq_expect(2, 1, 1, 12);

    // async reset while tap_n[2] is low
    cur_sc = 6; cfg_step = 4'd2; cfg_width = 4'd3;
    cyc(1'b1, 5'b11111, 1'b1, 1'b0, 0);
    seq_expect(2, 3, 1, 7);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (tap_n !== 5'b11111 || busy !== 1'b0 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got tap_n=%b busy=%b overrun=%b, expected tap_n=11111 busy=0 overrun=0",
               tap_n, busy, overrun);
    end
    cyc(1'b0, 5'b11111, 1'b0, 1'b0, 8);
    cyc(1'b0, 5'b11111, 1'b0, 1'b0, 9);
    reset_n = 1'b1;
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
